// File: rtl/drive_arbiter_if.sv
// drive_arbiter_if: command sources, motor-driver handshake and status bundle for drive_arbiter
interface drive_arbiter_if;
  logic       enable;
  logic       safety_stop;
  logic [2:0] manual_cmd;
  logic       manual_valid;
  logic [2:0] auto_cmd;
  logic       auto_valid;
  logic [2:0] out_cmd;
  logic       out_valid;
  logic       out_ready;
  logic       force_stop;
  logic [1:0] active_source;
  logic       watchdog_trip;
  modport master (
    output enable, safety_stop, manual_cmd, manual_valid, auto_cmd, auto_valid, out_ready,
    input  out_cmd, out_valid, force_stop, active_source, watchdog_trip
  );
  modport slave (
    input  enable, safety_stop, manual_cmd, manual_valid, auto_cmd, auto_valid, out_ready,
    output out_cmd, out_valid, force_stop, active_source, watchdog_trip
  );
endinterface

// File: rtl/drive_arbiter.sv
// drive_arbiter: safety/manual/auto drive command arbitration with dwell, manual hold and auto watchdog
module drive_arbiter #(
  parameter int MIN_DWELL   = 50_000,
  parameter int MANUAL_HOLD = 25_000_000,
  parameter int WATCHDOG    = 5_000_000
) (
  input logic clk,
  input logic reset,
  drive_arbiter_if.slave bus
);
  localparam int DW = MIN_DWELL   > 0 ? $clog2(MIN_DWELL + 1)   : 1;
  localparam int MW = MANUAL_HOLD > 0 ? $clog2(MANUAL_HOLD + 1) : 1;
  localparam int WW = WATCHDOG    > 0 ? $clog2(WATCHDOG + 1)    : 1;
  localparam logic [DW-1:0] DWELL_L = DW'(MIN_DWELL);
  localparam logic [MW-1:0] HOLD_L  = MW'(MANUAL_HOLD);
  localparam logic [WW-1:0] WD_L    = WW'(WATCHDOG);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_n;
  logic [2:0] man_reg, auto_reg, last_issued, target;
  logic [MW-1:0] man_timer;
  logic [DW-1:0] dwell_cnt;
  logic [WW-1:0] wd_cnt, wd_nx;
  logic auto_seen, issue, xfer;
  logic [1:0] sel;
  function automatic logic [2:0] legal(input logic [2:0] c);
    return c > 3'd5 ? 3'd0 : c;
  endfunction
  always_comb begin
    sel = bus.force_stop ? 2'd3 : man_timer != '0 ? 2'd2 : (auto_seen && !bus.watchdog_trip) ? 2'd1 : 2'd0;
    target = sel == 2'd2 ? man_reg : sel == 2'd1 ? auto_reg : 3'd0;
    xfer = state == BUSY && bus.out_ready;
    issue = state == IDLE && target != last_issued && (target == 3'd0 || dwell_cnt == '0);
    state_n = issue ? BUSY : xfer ? IDLE : state;
    wd_nx = wd_cnt == WD_L ? wd_cnt : wd_cnt + 1'b1;
  end
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  assign bus.out_valid = state == BUSY;
  always_ff @(posedge clk) begin
    if (reset) begin
      man_reg <= '0;
      man_timer <= '0;
      auto_reg <= '0;
      auto_seen <= 1'b0;
      wd_cnt <= '0;
      bus.watchdog_trip <= 1'b0;
      bus.force_stop <= 1'b1;
    end else begin
      bus.force_stop <= !bus.enable || bus.safety_stop;
      if (bus.manual_valid) begin
        man_reg <= legal(bus.manual_cmd);
        man_timer <= HOLD_L;
      end else if (man_timer != '0) man_timer <= man_timer - 1'b1;
      if (bus.auto_valid) begin
        auto_reg <= legal(bus.auto_cmd);
        auto_seen <= 1'b1;
        wd_cnt <= '0;
        bus.watchdog_trip <= 1'b0;
      end else begin
        wd_cnt <= wd_nx;
        if (wd_nx == WD_L) bus.watchdog_trip <= 1'b1;
      end
    end
  end
  // out_cmd only loads on issue, so it stays frozen while the driver stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_cmd <= '0;
      bus.active_source <= '0;
      last_issued <= '0;
      dwell_cnt <= '0;
    end else begin
      bus.active_source <= sel;
      if (issue) bus.out_cmd <= target;
      if (xfer) begin
        last_issued <= bus.out_cmd;
        dwell_cnt <= DWELL_L;
      end else if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_drive_arbiter.sv
// tb_drive_arbiter: directed scenarios plus randomized traffic against a timestamp-based reference model
module tb_drive_arbiter;
  localparam int DWELL = 20;
  localparam int HOLD  = 100;
  localparam int WD    = 64;
  logic clk = 1'b0;
  logic reset;
  int passed = 0;
  int total = 0;
  drive_arbiter_if bus ();
  drive_arbiter #(.MIN_DWELL(DWELL), .MANUAL_HOLD(HOLD), .WATCHDOG(WD)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int e = 0, man_t, auto_t, acc_t, s;
  bit m_force, auto_seen, m_pend, m_trip, own_man, auto_ok, xf, is;
  logic [2:0] m_cmd, m_last, m_man, m_auto, tgt;
  logic [1:0] m_act;
  function automatic logic [2:0] fix(input logic [2:0] c);
    return c > 3'd5 ? 3'd0 : c;
  endfunction
  // Ownership and timeouts are judged from edge timestamps rather than counters
  always @(posedge clk) begin
    e = e + 1;
    if (reset) begin
      m_force = 1; m_cmd = 0; m_pend = 0; m_act = 0; m_last = 0; m_man = 0; m_auto = 0;
      man_t = -1_000_000; acc_t = -1_000_000; auto_t = e; auto_seen = 0;
    end else begin
      own_man = (e - 1 - man_t) < HOLD;
      auto_ok = auto_seen && (e - 1 - auto_t) < WD;
      s = m_force ? 3 : own_man ? 2 : auto_ok ? 1 : 0;
      tgt = s == 2 ? m_man : s == 1 ? m_auto : 3'd0;
      xf = m_pend && bus.out_ready;
      is = !m_pend && tgt != m_last && (tgt == 0 || e - acc_t > DWELL);
      m_act = 2'(s);
      if (xf) begin m_pend = 0; m_last = m_cmd; acc_t = e; end
      if (is) begin m_pend = 1; m_cmd = tgt; end
      m_force = !bus.enable || bus.safety_stop;
      if (bus.manual_valid) begin m_man = fix(bus.manual_cmd); man_t = e; end
      if (bus.auto_valid) begin m_auto = fix(bus.auto_cmd); auto_t = e; auto_seen = 1; end
    end
    m_trip = (e - auto_t) >= WD;
  end
  task automatic chk(input string n, input int a, input int x);
    total++;
    if (a == x) passed++;
    else $display("FAIL %s: got %0d expected %0d at edge %0d", n, a, x, e);
  endtask
  task automatic tick();
    @(negedge clk);
    chk("out_valid", int'(bus.out_valid), int'(m_pend));
    chk("out_cmd", int'(bus.out_cmd), int'(m_cmd));
    chk("force_stop", int'(bus.force_stop), int'(m_force));
    chk("active_source", int'(bus.active_source), int'(m_act));
    chk("watchdog_trip", int'(bus.watchdog_trip), int'(m_trip));
  endtask
  initial begin
    reset = 1;
    bus.enable = 1; bus.safety_stop = 0; bus.manual_cmd = 0; bus.manual_valid = 0;
    bus.auto_cmd = 0; bus.auto_valid = 0; bus.out_ready = 1;
    tick();
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_force", int'(bus.force_stop), 1);
    chk("rst_src", int'(bus.active_source), 0);
    chk("rst_trip", int'(bus.watchdog_trip), 0);
    tick();
    reset = 0;
    repeat (3) tick();
    bus.auto_valid = 1; bus.auto_cmd = 3;
    tick();
    bus.auto_valid = 0;
    tick();
    chk("t1_valid", int'(bus.out_valid), 1);
    chk("t1_cmd", int'(bus.out_cmd), 3);
    chk("t1_src", int'(bus.active_source), 1);
    chk("t1_model_cmd", int'(m_cmd), 3);
    tick();
    chk("t1_pulse", int'(bus.out_valid), 0);
    bus.auto_valid = 1; bus.auto_cmd = 2;
    tick();
    bus.auto_valid = 0;
    repeat (10) tick();
    chk("t2_dwell_hold", int'(bus.out_valid), 0);
    repeat (15) tick();
    chk("t2_after_dwell", int'(bus.out_cmd), 2);
    bus.auto_valid = 1; bus.auto_cmd = 0;
    tick();
    bus.auto_valid = 0;
    tick();
    chk("t2_stop_valid", int'(bus.out_valid), 1);
    chk("t2_stop_cmd", int'(bus.out_cmd), 0);
    repeat (70) tick();
    chk("t6_trip", int'(bus.watchdog_trip), 1);
    chk("t6_src", int'(bus.active_source), 0);
    chk("t6_model_trip", int'(m_trip), 1);
    bus.manual_valid = 1; bus.manual_cmd = 1;
    tick();
    bus.manual_valid = 0;
    tick();
    chk("t4_valid", int'(bus.out_valid), 1);
    chk("t4_cmd", int'(bus.out_cmd), 1);
    chk("t4_src", int'(bus.active_source), 2);
    tick();
    bus.out_ready = 0; bus.manual_valid = 1; bus.manual_cmd = 6;
    tick();
    bus.manual_valid = 0;
    tick();
    chk("code6_valid", int'(bus.out_valid), 1);
    chk("code6_cmd", int'(bus.out_cmd), 0);
    bus.manual_valid = 1; bus.manual_cmd = 2;
    tick();
    bus.manual_valid = 0;
    repeat (4) tick();
    bus.manual_valid = 1; bus.manual_cmd = 4;
    tick();
    bus.manual_valid = 0;
    repeat (4) tick();
    chk("t5_held", int'(bus.out_cmd), 0);
    chk("t5_held_valid", int'(bus.out_valid), 1);
    bus.out_ready = 1;
    tick();
    repeat (25) tick();
    chk("t5_last_wins", int'(bus.out_cmd), 4);
    bus.auto_valid = 1; bus.auto_cmd = 5;
    tick();
    bus.auto_valid = 0;
    chk("t6_trip_clear", int'(bus.watchdog_trip), 0);
    for (int i = 0; i < 3000; i++) begin
      reset = $urandom_range(0, 599) == 0;
      bus.enable = $urandom_range(0, 49) != 0;
      bus.safety_stop = $urandom_range(0, 29) == 0;
      bus.manual_valid = $urandom_range(0, 149) == 0;
      bus.manual_cmd = 3'($urandom);
      bus.auto_valid = (i % 800 < 600) && $urandom_range(0, 15) == 0;
      bus.auto_cmd = 3'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    reset = 0; bus.manual_valid = 0; bus.auto_valid = 0; bus.out_ready = 1;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
